regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x N-bit register file between two writeback requesters: ALU writeback (req0) and load/multicycle unit (req1).
- Tracks destination registers with pending writes in a 32-entry busy scoreboard and raises a read-hazard stall for the issue stage.
- Sits between the writeback sources and the register file's `wr_addr`/`wr_data`/`wr_ena` inputs.

---
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Round-robin between ALU writeback (req0) and load/multicycle writeback (req1).
// One registered write slot, and a 32-entry busy scoreboard that drives the issue-stage stall.
module regfile_wb_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [4:0]   req0_addr,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_addr,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic [4:0]   wr_addr,
    output logic [N-1:0] wr_data,
    output logic         wr_ena,
    input  logic         reserve_ena,
    input  logic [4:0]   reserve_addr,
    input  logic [4:0]   rd_addr0,
    input  logic [4:0]   rd_addr1,
    output logic         stall,
    output logic [31:0]  busy,
    output logic [5:0]   pending_cnt,
    output logic         err_double_reserve
);

    logic         last_grant_q;
    logic [4:0]   wr_addr_q;
    logic [N-1:0] wr_data_q;
    logic         wr_ena_q;
    logic [31:0]  busy_q;
    logic [31:0]  busy_d;
    logic [5:0]   pending_cnt_q;
    logic         err_q;

    logic         grant0;
    logic         grant1;
    logic         hs;
    logic [4:0]   g_addr;
    logic [N-1:0] g_data;
    logic [31:0]  set_mask;
    logic [31:0]  clr_mask;
    logic         dbl_hit;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Round-robin grant: the requester that did not win last time wins a tie.
    always_comb begin
        grant0 = rst & req0_valid & (~req1_valid | last_grant_q);
        grant1 = rst & req1_valid & (~req0_valid | ~last_grant_q);
        hs     = grant0 | grant1;
        g_addr = grant1 ? req1_addr : req0_addr;
        g_data = grant1 ? req1_data : req0_data;
    end

    // Scoreboard next state: a reservation overrides a same-cycle clear, and r0 never goes busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (reserve_ena && (reserve_addr != 5'd0)) begin
            set_mask[reserve_addr] = 1'b1;
        end
        if (wr_ena_q) begin
            clr_mask[wr_addr_q] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        dbl_hit   = |(set_mask & busy_q & ~clr_mask);
    end

    // Write slot and grant history: capture the winner, suppress the enable for r0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_ena_q     <= 1'b0;
        end else if (hs) begin
            last_grant_q <= grant1;
            wr_addr_q    <= g_addr;
            wr_data_q    <= g_data;
            wr_ena_q     <= (g_addr != 5'd0);
        end else begin
            wr_ena_q     <= 1'b0;
        end
    end

    // Busy bits, their registered popcount, and the sticky double-reserve flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q        <= '0;
            pending_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            pending_cnt_q <= popcount32(busy_d);
            if (dbl_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // An in-flight write is dropped if reset arrives before the register file commits it.
    assign wr_ena             = wr_ena_q & rst;
    assign wr_addr            = wr_addr_q;
    assign wr_data            = wr_data_q;
    assign req0_ready         = grant0;
    assign req1_ready         = grant1;
    assign stall              = rst & (busy_q[rd_addr0] | busy_q[rd_addr1]);
    assign busy               = busy_q;
    assign pending_cnt        = pending_cnt_q;
    assign err_double_reserve = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [4:0]   req0_addr, req1_addr;
    logic [N-1:0] req0_data, req1_data;
    logic [4:0]   wr_addr;
    logic [N-1:0] wr_data;
    logic         wr_ena;
    logic         reserve_ena;
    logic [4:0]   reserve_addr, rd_addr0, rd_addr1;
    logic         stall;
    logic [31:0]  busy;
    logic [5:0]   pending_cnt;
    logic         err_double_reserve;

    int checks = 0;
    int errors = 0;

    // Register file driven by the DUT write port; r0 is read back as stored.
    logic [N-1:0] rf [32];

    // Behavioural model state
    int           m_lg;
    bit           m_wv;
    logic [4:0]   m_wa;
    logic [N-1:0] m_wd;
    bit           m_busy [32];
    bit           m_err;
    logic [N-1:0] m_rf [32];

    regfile_wb_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena),
        .reserve_ena(reserve_ena), .reserve_addr(reserve_addr),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .stall(stall), .busy(busy), .pending_cnt(pending_cnt),
        .err_double_reserve(err_double_reserve)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_ena) rf[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which requester the rules say wins this cycle (-1 = none).
    function automatic int exp_grant();
        if (!rst) return -1;
        if (req0_valid && req1_valid) return (m_lg == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        m_lg = 1; m_wv = 0; m_wa = '0; m_wd = '0; m_err = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    task automatic idle_in();
        rst = 1'b1;
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        reserve_ena = 0; reserve_addr = '0; rd_addr0 = '0; rd_addr1 = '0;
    endtask

    // Check all outputs against the model for the current inputs, then advance one clock.
    task automatic tick();
        int g;
        bit was_busy;
        bit stall_e;
        #1;
        g = exp_grant();
        stall_e = rst && (m_busy[rd_addr0] || m_busy[rd_addr1]);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("stall", stall, stall_e);
        chk("wr_ena", wr_ena, m_wv && rst);
        chk("wr_addr", wr_addr, m_wa);
        chk("wr_data", wr_data, m_wd);
        chk("busy", busy, m_busy_vec());
        chk("pending_cnt", pending_cnt, m_count());
        chk("err_double_reserve", err_double_reserve, m_err);
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_wv) m_rf[m_wa] = m_wd;
            if (reserve_ena && reserve_addr != 0) begin
                was_busy = m_busy[reserve_addr] && !(m_wv && m_wa == reserve_addr);
                if (was_busy) m_err = 1;
            end
            if (m_wv) m_busy[m_wa] = 0;
            if (reserve_ena && reserve_addr != 0) m_busy[reserve_addr] = 1;
            if (g >= 0) begin
                m_wa = (g == 1) ? req1_addr : req0_addr;
                m_wd = (g == 1) ? req1_data : req0_data;
                m_wv = (m_wa != 0);
                m_lg = g;
            end else begin
                m_wv = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i] = '0;
            m_rf[i] = '0;
        end
        idle_in();
        rst = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        tick();
        chk("reset_busy", busy, 32'd0);
        chk("reset_wr_ena", wr_ena, 1'b0);

        // 1: single req0 write of r5
        idle_in();
        req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        tick();
        idle_in();
        tick();
        tick();
        chk("rf_r5", rf[5], 32'hDEADBEEF);

        // 2: both requesters for four cycles, starting from reset
        do_reset();
        idle_in();
        req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h22;
        repeat (4) tick();
        idle_in();
        tick();
        tick();
        chk("rf_r1", rf[1], 32'h11);
        chk("rf_r2", rf[2], 32'h22);

        // 3: reserve r7, stall on it, then clear it through req1
        idle_in();
        reserve_ena = 1; reserve_addr = 5'd7;
        tick();
        idle_in();
        rd_addr0 = 5'd7;
        tick();
        chk("stall_r7", stall, 1'b1);
        chk("cnt_r7", pending_cnt, 6'd1);
        req1_valid = 1; req1_addr = 5'd7; req1_data = 32'h77;
        tick();
        req1_valid = 0;
        tick();
        tick();
        chk("stall_r7_clear", stall, 1'b0);
        chk("rf_r7", rf[7], 32'h77);

        // 4: writes and reservations of r0 are harmless
        idle_in();
        req0_valid = 1; req0_addr = 5'd0; req0_data = 32'hFFFFFFFF;
        tick();
        idle_in();
        reserve_ena = 1; reserve_addr = 5'd0;
        tick();
        idle_in();
        tick();
        chk("rf_r0", rf[0], 32'd0);
        chk("busy_r0", busy, 32'd0);

        // 5: reserve coinciding with the clear is fine; a true double reserve is sticky
        do_reset();
        idle_in();
        reserve_ena = 1; reserve_addr = 5'd9;
        tick();
        idle_in();
        req0_valid = 1; req0_addr = 5'd9; req0_data = 32'h99;
        tick();
        idle_in();
        reserve_ena = 1; reserve_addr = 5'd9;
        tick();
        idle_in();
        tick();
        chk("err_no_double", err_double_reserve, 1'b0);
        chk("busy9_kept", busy[9], 1'b1);
        reserve_ena = 1; reserve_addr = 5'd9;
        tick();
        idle_in();
        tick();
        tick();
        chk("err_sticky", err_double_reserve, 1'b1);

        // 6: reset right after a req1 handshake drops the write to r3
        idle_in();
        reserve_ena = 1; reserve_addr = 5'd3;
        tick();
        idle_in();
        req1_valid = 1; req1_addr = 5'd3; req1_data = 32'h33;
        tick();
        idle_in();
        req1_valid = 1; req1_addr = 5'd3; req1_data = 32'h33;
        rst = 1'b0;
        tick();
        tick();
        chk("rf_r3_kept", rf[3], 32'd0);
        idle_in();
        tick();

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst          = ($urandom_range(0, 39) != 0);
            req0_valid   = $urandom_range(0, 1);
            req0_addr    = 5'($urandom_range(0, 7));
            req0_data    = $urandom;
            req1_valid   = $urandom_range(0, 1);
            req1_addr    = 5'($urandom_range(0, 7));
            req1_data    = $urandom;
            reserve_ena  = ($urandom_range(0, 2) == 0);
            reserve_addr = 5'($urandom_range(0, 9));
            rd_addr0     = 5'($urandom_range(0, 9));
            rd_addr1     = 5'($urandom_range(0, 31));
            tick();
        end
        idle_in();
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("rf_final", rf[i], m_rf[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
